// File: rtl/whack_gfx_pkg.sv
// -----------------------------------------------------------------------------
// whack_gfx_pkg
// Shared definitions for the whack graphics blocks.
//   blit_state_t         : blitter FSM state encoding
//   TRANS_COLOUR_DEFAULT : default 12-bit colour key (magenta) treated as
//                          transparent
//   width_min1()         : $clog2 that never returns less than one bit, for
//                          select/counter fields that must exist even when
//                          only one value is possible
// -----------------------------------------------------------------------------
package whack_gfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_t;

  localparam logic [11:0] TRANS_COLOUR_DEFAULT = 12'hF0F;

  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// -----------------------------------------------------------------------------
// blit_addr_gen
// Walks a source image in row-major order: one linear ROM address per
// advance, with the matching column/row so the caller can place the pixel.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart at pixel 0 (address, column and row all zero)
//   advance    : step to the next pixel
//   addr       : linear ROM address (registered)
//   col, row   : column/row of the pixel at addr (registered)
//   last       : addr is the final pixel of the image
// -----------------------------------------------------------------------------
module blit_addr_gen
  import whack_gfx_pkg::*;
#(
  parameter int  IMG_W = 160,
  parameter int  IMG_H = 120,
  localparam int AW    = width_min1(IMG_W * IMG_H),
  localparam int CW    = width_min1(IMG_W),
  localparam int RW    = width_min1(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);

  // NOTE: clocked state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (clear) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (advance) begin
      addr <= addr + 1'b1;
      if (col == COL_MAX) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (addr == LAST_ADDR);

endmodule

// File: rtl/image_blitter.sv
// -----------------------------------------------------------------------------
// image_blitter
// Copies one IMG_W x IMG_H image from a selectable ROM onto the screen at a
// given offset, producing vga_adapter plot strobes. One pixel per clock, no
// stalls. Pixels falling off the right/bottom screen edge are clipped, and an
// optional colour key suppresses transparent pixels.
// Ports:
//   iClock, iResetn     : clock, asynchronous active-low reset
//   iStart              : blit request, only honoured while idle
//   iImgSel             : which image ROM to read
//   iXOff, iYOff        : screen position of the image top-left corner
//   iTransEn            : enable colour-key transparency
//   oRomAddr, oRomSel   : registered ROM address (row-major) and ROM select
//   iRomData            : ROM colour, valid one cycle after oRomAddr
//   oX, oY, oColour     : registered plot coordinate and colour
//   oPlot               : registered write strobe
//   oBusy               : blit in progress (through the oDone cycle)
//   oDone               : one-cycle pulse after the final pixel slot
// Timing: address k is registered k edges after the accepting edge; its
// pixel appears on the outputs two edges later, once iRomData is available.
// -----------------------------------------------------------------------------
module image_blitter
  import whack_gfx_pkg::*;
#(
  parameter int                  IMG_W        = 160,
  parameter int                  IMG_H        = 120,
  parameter int                  SCR_W        = 160,
  parameter int                  SCR_H        = 120,
  parameter int                  COLOUR_W     = 12,
  parameter int                  NUM_IMG      = 4,
  parameter logic [COLOUR_W-1:0] TRANS_COLOUR = COLOUR_W'(TRANS_COLOUR_DEFAULT),
  localparam int                 XW           = $clog2(SCR_W),
  localparam int                 YW           = $clog2(SCR_H),
  localparam int                 SW           = width_min1(NUM_IMG),
  localparam int                 AW           = width_min1(IMG_W * IMG_H)
) (
  input  logic                iClock,
  input  logic                iResetn,
  input  logic                iStart,
  input  logic [SW-1:0]       iImgSel,
  input  logic [XW-1:0]       iXOff,
  input  logic [YW-1:0]       iYOff,
  input  logic                iTransEn,
  output logic [AW-1:0]       oRomAddr,
  output logic [SW-1:0]       oRomSel,
  input  logic [COLOUR_W-1:0] iRomData,
  output logic [XW-1:0]       oX,
  output logic [YW-1:0]       oY,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oPlot,
  output logic                oBusy,
  output logic                oDone
);

  localparam int CW = width_min1(IMG_W);
  localparam int RW = width_min1(IMG_H);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  blit_state_t state, state_nxt;
  logic        flush_cnt;   // second FLUSH cycle when set
  logic        addr_last;
  logic        accept, advance, addr_valid, busy_nxt, done_nxt;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state     <= ST_IDLE;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == ST_FLUSH) ? ~flush_cnt : 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (iStart)    state_nxt = ST_DRAW;
      ST_DRAW:  if (addr_last) state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_cnt) state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every signal produced by an always_comb is assigned on every path
  // (here, unconditionally), so no latch can be inferred.
  always_comb begin
    accept     = (state == ST_IDLE) && iStart;
    advance    = (state == ST_DRAW) && !addr_last;
    addr_valid = (state == ST_DRAW);
    busy_nxt   = (state_nxt != ST_IDLE);
    done_nxt   = (state_nxt == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Request capture: everything the blit needs is frozen on the accepting edge
  // so later input changes cannot disturb the image in flight.
  // ---------------------------------------------------------------------------
  logic [XW-1:0] xoff_q;
  logic [YW-1:0] yoff_q;
  logic          trans_q;

  // NOTE: this block holds only a handful of flops (no RAM arrays), so every
  // register, datapath included, gets a reset value.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      oRomSel <= '0;
      xoff_q  <= '0;
      yoff_q  <= '0;
      trans_q <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      if (accept) begin
        oRomSel <= iImgSel;
        xoff_q  <= iXOff;
        yoff_q  <= iYOff;
        trans_q <= iTransEn;
      end
      oBusy <= busy_nxt;
      oDone <= done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Address generation
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  blit_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_addr_gen (
    .clk     (iClock),
    .rst_n   (iResetn),
    .clear   (accept),
    .advance (advance),
    .addr    (oRomAddr),
    .col     (col),
    .row     (row),
    .last    (addr_last)
  );

  // ---------------------------------------------------------------------------
  // Stage 1: screen coordinate of the pixel whose address went out last
  // cycle. One extra bit keeps off-screen sums from wrapping back on-screen.
  // ---------------------------------------------------------------------------
  logic          s1_valid;
  logic [XW:0]   s1_x;
  logic [YW:0]   s1_y;
  logic          s1_on_screen;
  logic          key_hit;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= addr_valid;
      if (addr_valid) begin
        s1_x <= {1'b0, xoff_q} + (XW+1)'(col);
        s1_y <= {1'b0, yoff_q} + (YW+1)'(row);
      end
    end
  end

  assign s1_on_screen = (s1_x < (XW+1)'(SCR_W)) && (s1_y < (YW+1)'(SCR_H));
  assign key_hit      = trans_q && (iRomData == TRANS_COLOUR);

  // ---------------------------------------------------------------------------
  // Stage 2: plot outputs, aligned with iRomData. Coordinates and colour track
  // every slot; only the strobe is gated by clipping and the colour key.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      oX      <= '0;
      oY      <= '0;
      oColour <= '0;
      oPlot   <= 1'b0;
    end else begin
      oPlot <= s1_valid && s1_on_screen && !key_hit;
      if (s1_valid) begin
        oX      <= s1_x[XW-1:0];
        oY      <= s1_y[YW-1:0];
        oColour <= iRomData;
      end
    end
  end

endmodule

// File: tb/tb_image_blitter.sv
// -----------------------------------------------------------------------------
// tb_image_blitter
// Self-checking bench for image_blitter with a 4x2 image on a 160x120 screen.
// A bench-side ROM answers oRomAddr one cycle later. A behavioural model turns
// each accepted start into a per-edge table of expected slots, plots, busy and
// done; a compare process checks the DUT against that table on every falling
// edge. Directed scenarios add literal expectations on counts and coordinates.
// -----------------------------------------------------------------------------
module tb_image_blitter;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int N     = IMG_W * IMG_H;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int XW    = 8;
  localparam int YW    = 7;
  localparam int SW    = 2;
  localparam int AW    = 3;
  localparam int MAXC  = 1024;
  localparam logic [11:0] KEY = 12'hF0F;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          trans_en = 1'b0;
  logic [SW-1:0] img_sel = '0;
  logic [XW-1:0] x_off = '0;
  logic [YW-1:0] y_off = '0;
  logic [11:0]   rom_data = '0;
  logic [AW-1:0] rom_addr;
  logic [SW-1:0] rom_sel;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [11:0]   colour;
  logic          plot, busy, done;

  image_blitter #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .SCR_W    (SCR_W),
    .SCR_H    (SCR_H),
    .COLOUR_W (12),
    .NUM_IMG  (4)
  ) dut (
    .iClock   (clk),
    .iResetn  (rst_n),
    .iStart   (start),
    .iImgSel  (img_sel),
    .iXOff    (x_off),
    .iYOff    (y_off),
    .iTransEn (trans_en),
    .oRomAddr (rom_addr),
    .oRomSel  (rom_sel),
    .iRomData (rom_data),
    .oX       (px),
    .oY       (py),
    .oColour  (colour),
    .oPlot    (plot),
    .oBusy    (busy),
    .oDone    (done)
  );

  always #5 clk = ~clk;

  // Image s pixel k has colour s*16+k, except image 1 pixel 3 is the key.
  function automatic logic [11:0] rom_val(input int sel, input int k);
    if (sel == 1 && k == 3) return KEY;
    return 12'(sel * 16 + k);
  endfunction

  always @(posedge clk) rom_data <= rom_val(int'(rom_sel), int'(rom_addr));

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: an accepted start at edge e owns edges e..e+N+2.
  // Slot k is shown at edge e+2+k, oDone at e+N+2, idle again at e+N+3, and
  // the next start can be taken at e+N+4.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit slot;
    bit plot;
    bit done;
    bit busy;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t exq [MAXC];
  int   free_edge   = 0;
  int   model_sel   = 0;
  int   accept_edge = -1;
  int   mx, my, mc;

  always @(posedge clk) begin
    edge_n++;
    if (rst_n && start && edge_n >= free_edge && edge_n + N + 4 < MAXC) begin
      accept_edge = edge_n;
      model_sel   = int'(img_sel);
      free_edge   = edge_n + N + 4;
      for (int e = edge_n; e <= edge_n + N + 2; e++) exq[e].busy = 1'b1;
      exq[edge_n + N + 2].done = 1'b1;
      for (int k = 0; k < N; k++) begin
        mx = int'(x_off) + (k % IMG_W);
        my = int'(y_off) + (k / IMG_W);
        mc = int'(rom_val(model_sel, k));
        exq[edge_n + 2 + k].slot = 1'b1;
        exq[edge_n + 2 + k].x    = mx;
        exq[edge_n + 2 + k].y    = my;
        exq[edge_n + 2 + k].c    = mc;
        exq[edge_n + 2 + k].plot = (mx < SCR_W) && (my < SCR_H) &&
                                   !(trans_en && mc == int'(KEY));
      end
    end
  end

  // Per-scenario tallies of what the DUT actually plotted.
  int  plot_cnt, done_cnt, first_edge, last_edge, done_edge, first_done_edge;
  int  first_x, first_y, first_c, last_x, last_y, last_c;
  bit  seen_plot, seen_done;

  task automatic clear_tallies();
    plot_cnt = 0; done_cnt = 0; seen_plot = 1'b0; seen_done = 1'b0;
    first_edge = -1; last_edge = -1; done_edge = -1; first_done_edge = -1;
    first_x = -1; first_y = -1; first_c = -1;
    last_x = -1; last_y = -1; last_c = -1;
  endtask

  always @(negedge clk) begin
    if (edge_n > 0 && edge_n < MAXC) begin
      check("plot",    32'(plot),    32'(exq[edge_n].plot));
      check("done",    32'(done),    32'(exq[edge_n].done));
      check("busy",    32'(busy),    32'(exq[edge_n].busy));
      check("rom_sel", 32'(rom_sel), 32'(model_sel));
      if (exq[edge_n].slot) begin
        check("x",      32'(px),     32'(exq[edge_n].x));
        check("y",      32'(py),     32'(exq[edge_n].y));
        check("colour", 32'(colour), 32'(exq[edge_n].c));
      end
      if (plot === 1'b1) begin
        plot_cnt++;
        if (!seen_plot) begin
          seen_plot = 1'b1; first_edge = edge_n;
          first_x = int'(px); first_y = int'(py); first_c = int'(colour);
        end
        last_edge = edge_n;
        last_x = int'(px); last_y = int'(py); last_c = int'(colour);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_edge = edge_n;
        if (!seen_done) begin
          seen_done = 1'b1; first_done_edge = edge_n;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic blit(input int sel, input int xo, input int yo, input bit te);
    img_sel  = SW'(sel);
    x_off    = XW'(xo);
    y_off    = YW'(yo);
    trans_en = te;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    // Disturb the request inputs while the blit runs.
    img_sel  = SW'($urandom);
    x_off    = XW'($urandom);
    y_off    = YW'($urandom);
    trans_en = 1'($urandom);
    repeat (N + 6) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_plot"},   32'(plot),     32'd0);
    check({tag, "_done"},   32'(done),     32'd0);
    check({tag, "_busy"},   32'(busy),     32'd0);
    check({tag, "_addr"},   32'(rom_addr), 32'd0);
    check({tag, "_sel"},    32'(rom_sel),  32'd0);
    check({tag, "_x"},      32'(px),       32'd0);
    check({tag, "_y"},      32'(py),       32'd0);
    check({tag, "_colour"}, 32'(colour),   32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    clear_tallies();
    repeat (2) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 4x2 blit at (10,20), colours 0..7.
    clear_tallies();
    blit(0, 10, 20, 1'b0);
    check("t1_plots",      32'(plot_cnt), 32'd8);
    check("t1_dones",      32'(done_cnt), 32'd1);
    check("t1_first_x",    32'(first_x),  32'd10);
    check("t1_first_y",    32'(first_y),  32'd20);
    check("t1_first_c",    32'(first_c),  32'd0);
    check("t1_last_x",     32'(last_x),   32'd13);
    check("t1_last_y",     32'(last_y),   32'd21);
    check("t1_last_c",     32'(last_c),   32'd7);
    check("t1_latency",    32'(first_edge - accept_edge), 32'd2);
    check("t1_done_after", 32'(done_edge - last_edge),    32'd1);

    // Clipping at the bottom-right corner.
    clear_tallies();
    blit(0, 158, 119, 1'b0);
    check("t2_plots",   32'(plot_cnt), 32'd2);
    check("t2_dones",   32'(done_cnt), 32'd1);
    check("t2_first_x", 32'(first_x),  32'd158);
    check("t2_first_y", 32'(first_y),  32'd119);
    check("t2_last_x",  32'(last_x),   32'd159);
    check("t2_last_y",  32'(last_y),   32'd119);
    check("t2_span",    32'(done_edge - accept_edge), 32'(N + 2));

    // Colour key on image 1 (pixel 3 is transparent), then with keying off.
    clear_tallies();
    blit(1, 30, 40, 1'b1);
    check("t3_plots_key", 32'(plot_cnt), 32'd7);
    check("t3_dones_key", 32'(done_cnt), 32'd1);
    clear_tallies();
    blit(1, 30, 40, 1'b0);
    check("t3_plots_nokey", 32'(plot_cnt), 32'd8);
    check("t3_key_c",       32'(rom_val(1, 3)), 32'h0F0F);

    // Second start mid-blit with a different image: ignored.
    clear_tallies();
    img_sel = 2'd0; x_off = 8'd50; y_off = 7'd60; trans_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    img_sel = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_sel_held", 32'(rom_sel), 32'd0);
    repeat (N + 4) @(negedge clk);
    check("t4_dones",  32'(done_cnt), 32'd1);
    check("t4_plots",  32'(plot_cnt), 32'd8);
    check("t4_last_c", 32'(last_c),   32'd7);

    // Reset in the middle of DRAW, then a clean blit.
    img_sel = 2'd3; x_off = 8'd5; y_off = 7'd5; trans_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    for (int i = edge_n + 1; i < MAXC; i++) exq[i] = '{default: 0};
    free_edge = 0;
    model_sel = 0;
    #1;
    check_all_zero("rst");
    clear_tallies();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_no_plots", 32'(plot_cnt), 32'd0);
    check("t5_no_done",  32'(done_cnt), 32'd0);
    blit(2, 0, 0, 1'b0);
    check("t5_plots",  32'(plot_cnt), 32'd8);
    check("t5_dones",  32'(done_cnt), 32'd1);
    check("t5_last_x", 32'(last_x),   32'd3);
    check("t5_last_y", 32'(last_y),   32'd1);
    check("t5_last_c", 32'(last_c),   32'h27);

    // iStart held high: two back-to-back blits with an idle cycle between.
    clear_tallies();
    img_sel = 2'd3; x_off = 8'd70; y_off = 7'd80; trans_en = 1'b0; start = 1'b1;
    repeat (13) @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    check("t6_dones",   32'(done_cnt), 32'd2);
    check("t6_plots",   32'(plot_cnt), 32'd16);
    check("t6_spacing", 32'(done_edge - first_done_edge), 32'(N + 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
